// File: rtl/mem_arbiter.sv
// Round-robin byte-serial arbiter between N_CH requesters and a byte-wide RAM/IO bus.
// Splits 1/2/4-byte accesses into little-endian byte transfers and stalls IO writes on a full UART.
module mem_arbiter #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   rdy_in,
    input  logic                   flush_in,
    input  logic [N_CH-1:0]        req_in,
    input  logic [N_CH-1:0]        we_in,
    input  logic [2*N_CH-1:0]      size_in,
    input  logic [ADDR_W*N_CH-1:0] addr_in,
    input  logic [32*N_CH-1:0]     wdata_in,
    output logic [N_CH-1:0]        gnt_out,
    output logic [N_CH-1:0]        done_out,
    output logic [31:0]            rdata_out,
    output logic                   busy_out,
    input  logic [7:0]             mem_din,
    output logic [7:0]             mem_dout,
    output logic [ADDR_W-1:0]      mem_a,
    output logic                   mem_wr,
    input  logic                   io_buffer_full
);

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, IO_WAIT} state_t;

    state_t            r_state, w_state;
    logic [CW-1:0]     r_ptr, w_ptr, r_win, w_win, w_sel;
    logic [2:0]        r_n, w_n, r_k, w_k, w_k1;
    logic [ADDR_W-1:0] r_addr, w_addr, w_ka, r_mem_a, w_mem_a, w_addr_s;
    logic [31:0]       r_wdata, w_wdata, r_buf, w_buf, w_cap, r_rdata, w_rdata, w_wd_s;
    logic [N_CH-1:0]   r_gnt, w_gnt, r_done, w_done, w_sel_oh, w_win_oh;
    logic [7:0]        r_dout, w_dout;
    logic              r_wr, w_wr, w_found, w_we_s;
    logic [1:0]        w_size_s;

    function automatic logic [7:0] byte_of(input logic [31:0] d, input logic [2:0] i);
        case (i[1:0])
            2'd0:    return d[7:0];
            2'd1:    return d[15:8];
            2'd2:    return d[23:16];
            default: return d[31:24];
        endcase
    endfunction

    function automatic logic [31:0] set_byte(input logic [31:0] d, input logic [2:0] i,
                                             input logic [7:0] b);
        logic [31:0] t;
        t = d;
        case (i[1:0])
            2'd0:    t[7:0]   = b;
            2'd1:    t[15:8]  = b;
            2'd2:    t[23:16] = b;
            default: t[31:24] = b;
        endcase
        return t;
    endfunction

    function automatic logic is_io(input logic [ADDR_W-1:0] a);
        logic [ADDR_W+17:0] t;
        t = {18'd0, a};
        return t[17:16] == 2'b11;
    endfunction

    function automatic logic [2:0] size_n(input logic [1:0] s);
        case (s)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Round-robin pick: first requester at or after ptr, else wrap to the lowest one.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!w_found && req_in[i] && (CW'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_sel   = CW'(i);
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (!w_found && req_in[i]) begin
                w_found = 1'b1;
                w_sel   = CW'(i);
            end
        end
    end

    // Mux out the selected channel's request fields and build one-hot vectors.
    always_comb begin
        w_we_s   = 1'b0;
        w_size_s = 2'd0;
        w_addr_s = '0;
        w_wd_s   = '0;
        w_sel_oh = '0;
        w_win_oh = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_sel_oh[i] = (CW'(i) == w_sel);
            w_win_oh[i] = (CW'(i) == r_win);
            if (CW'(i) == w_sel) begin
                w_we_s   = we_in[i];
                w_size_s = size_in[2*i +: 2];
                w_addr_s = addr_in[ADDR_W*i +: ADDR_W];
                w_wd_s   = wdata_in[32*i +: 32];
            end
        end
    end

    assign w_k1  = r_k + 3'd1;
    assign w_ka  = r_addr + ADDR_W'(w_k1);
    assign w_cap = set_byte(r_buf, r_k - 3'd1, mem_din);

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_win   = r_win;
        w_n     = r_n;
        w_k     = r_k;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_buf   = r_buf;
        w_rdata = r_rdata;
        w_mem_a = r_mem_a;
        w_dout  = r_dout;
        w_wr    = r_wr;
        w_gnt   = '0;
        w_done  = '0;
        unique case (r_state)
            IDLE: begin
                if (w_found && !flush_in) begin
                    w_win   = w_sel;
                    w_ptr   = (w_sel == CW'(N_CH - 1)) ? '0 : w_sel + 1'b1;
                    w_gnt   = w_sel_oh;
                    w_n     = size_n(w_size_s);
                    w_k     = 3'd0;
                    w_addr  = w_addr_s;
                    w_wdata = w_wd_s;
                    w_buf   = '0;
                    w_mem_a = w_addr_s;
                    if (!w_we_s) begin
                        w_state = READ;
                    end else if (is_io(w_addr_s) && io_buffer_full) begin
                        w_state = IO_WAIT;
                        w_wr    = 1'b0;
                    end else begin
                        w_state = WRITE;
                        w_dout  = w_wd_s[7:0];
                        w_wr    = 1'b1;
                    end
                end
            end
            READ: begin
                if (flush_in) begin
                    w_state = IDLE;
                end else begin
                    w_k = w_k1;
                    if (w_k1 < r_n) w_mem_a = w_ka;
                    if (r_k != 3'd0) w_buf = w_cap;
                    if (r_k == r_n) begin
                        w_rdata = w_cap;
                        w_done  = w_win_oh;
                        w_state = IDLE;
                    end
                end
            end
            WRITE: begin
                if (w_k1 < r_n) begin
                    w_k     = w_k1;
                    w_mem_a = w_ka;
                    if (is_io(w_ka) && io_buffer_full) begin
                        w_wr    = 1'b0;
                        w_state = IO_WAIT;
                    end else begin
                        w_dout = byte_of(r_wdata, w_k1);
                        w_wr   = 1'b1;
                    end
                end else begin
                    w_wr    = 1'b0;
                    w_done  = w_win_oh;
                    w_state = IDLE;
                end
            end
            IO_WAIT: begin
                if (!io_buffer_full) begin
                    w_dout  = byte_of(r_wdata, r_k);
                    w_wr    = 1'b1;
                    w_state = WRITE;
                end
            end
        endcase
    end

    // State register; a low rdy_in freezes every register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_n     <= 3'd0;
            r_k     <= 3'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_buf   <= '0;
            r_rdata <= '0;
            r_mem_a <= '0;
            r_dout  <= '0;
            r_wr    <= 1'b0;
            r_gnt   <= '0;
            r_done  <= '0;
        end else if (rdy_in) begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_win   <= w_win;
            r_n     <= w_n;
            r_k     <= w_k;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_buf   <= w_buf;
            r_rdata <= w_rdata;
            r_mem_a <= w_mem_a;
            r_dout  <= w_dout;
            r_wr    <= w_wr;
            r_gnt   <= w_gnt;
            r_done  <= w_done;
        end
    end

    assign gnt_out   = r_gnt;
    assign done_out  = r_done;
    assign rdata_out = r_rdata;
    assign busy_out  = (r_state != IDLE);
    assign mem_a     = r_mem_a;
    assign mem_dout  = r_dout;
    assign mem_wr    = r_wr & rdy_in;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte RAM model, expected completions queued at request time.
// Covers reset, word/half/byte reads, round-robin, wrap, IO stall, flush and global pause.
module tb_mem_arbiter;

    localparam int N_CH = 2;
    localparam int AW   = 32;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 rdy = 1'b1;
    logic                 flush = 1'b0;
    logic [N_CH-1:0]      req = '0;
    logic [N_CH-1:0]      we = '0;
    logic [2*N_CH-1:0]    size = '0;
    logic [AW*N_CH-1:0]   addr = '0;
    logic [32*N_CH-1:0]   wdata = '0;
    logic [N_CH-1:0]      gnt_out, done_out;
    logic [31:0]          rdata_out;
    logic                 busy_out;
    logic [7:0]           mem_din = 8'h00;
    logic [7:0]           mem_dout;
    logic [AW-1:0]        mem_a;
    logic                 mem_wr;
    logic                 io_full = 1'b0;

    typedef struct {
        int          ch;
        bit          rd;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t              sb[$];
    int                gnt_log[$];
    logic [39:0]       wr_log[$];
    logic [7:0]        mem[logic [31:0]];
    int                gnt_cyc[N_CH];
    int                cyc = 0;
    int                n_chk = 0;
    int                n_err = 0;
    int                w0;

    mem_arbiter #(.N_CH(N_CH), .ADDR_W(AW)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
        .req_in(req), .we_in(we), .size_in(size), .addr_in(addr), .wdata_in(wdata),
        .gnt_out(gnt_out), .done_out(done_out), .rdata_out(rdata_out), .busy_out(busy_out),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_full)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rdm(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RAM model: registered read, write on strobe.
    always @(posedge clk) begin
        cyc++;
        mem_din <= rdm(mem_a);
        if (mem_wr) begin
            mem[mem_a] = mem_dout;
            wr_log.push_back({mem_a, mem_dout});
        end
    end

    // Grant logger and completion scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt_out != '0) begin
                chk("gnt_onehot", 64'($countones(gnt_out)), 64'd1);
                for (int i = 0; i < N_CH; i++) begin
                    if (gnt_out[i]) begin
                        gnt_log.push_back(i);
                        gnt_cyc[i] = cyc;
                    end
                end
            end
            if (done_out != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(done_out), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_ch", 64'(done_out), 64'd1 << e.ch);
                    if (e.rd) chk("rdata", 64'(rdata_out), 64'(e.rdata));
                    if (e.lat > 0) chk("latency", 64'(cyc - gnt_cyc[e.ch]), 64'(e.lat));
                end
            end
        end
    end

    task automatic set_ch(input int ch, input bit w, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
        we[ch]           = w;
        size[2*ch +: 2]  = sz;
        addr[AW*ch +: AW] = a;
        wdata[32*ch +: 32] = d;
    endtask

    task automatic push(input int ch, input bit rd, input logic [31:0] v, input int lat);
        exp_t e;
        e.ch = ch;
        e.rd = rd;
        e.rdata = v;
        e.lat = lat;
        sb.push_back(e);
    endtask

    task automatic run_reqs();
        int b;
        b = 0;
        while (req != '0 && b < 100) begin
            @(negedge clk);
            for (int i = 0; i < N_CH; i++) if (gnt_out[i]) req[i] = 1'b0;
            b++;
        end
        if (req != '0) begin
            chk("gnt_timeout", 64'(req), 64'd0);
            req = '0;
        end
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((sb.size() != 0 || busy_out) && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (sb.size() != 0 || busy_out) begin
            chk("idle_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = '0;
        flush = 1'b0;
        rdy = 1'b1;
        io_full = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        gnt_log.delete();
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        mem[32'h100] = 8'h11; mem[32'h101] = 8'h22;
        mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
        mem[32'h200] = 8'hAA; mem[32'h201] = 8'hBB;
        mem[32'h202] = 8'hCC; mem[32'h203] = 8'hDD;
        mem[32'h204] = 8'hEE;

        do_reset();
        chk("rst_gnt", 64'(gnt_out), 64'd0);
        chk("rst_done", 64'(done_out), 64'd0);
        chk("rst_rdata", 64'(rdata_out), 64'd0);
        chk("rst_busy", 64'(busy_out), 64'd0);
        chk("rst_mem_a", 64'(mem_a), 64'd0);
        chk("rst_dout", 64'(mem_dout), 64'd0);
        chk("rst_wr", 64'(mem_wr), 64'd0);

        // word read, address sequence
        set_ch(0, 1'b0, 2'd2, 32'h100, 32'h0);
        push(0, 1'b1, 32'h44332211, 5);
        req = 2'b01;
        run_reqs();
        chk("t1_gnt", 64'(gnt_out), 64'd1);
        chk("t1_mem_a0", 64'(mem_a), 64'h100);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("t1_mem_a", 64'(mem_a), 64'h100 + 64'(i));
        end
        wait_idle();

        // round robin, two rounds
        do_reset();
        set_ch(0, 1'b0, 2'd2, 32'h100, 32'h0);
        set_ch(1, 1'b0, 2'd1, 32'h200, 32'h0);
        push(0, 1'b1, 32'h44332211, 5);
        push(1, 1'b1, 32'h0000BBAA, 3);
        req = 2'b11;
        run_reqs();
        set_ch(0, 1'b0, 2'd0, 32'h102, 32'h0);
        set_ch(1, 1'b0, 2'd3, 32'h201, 32'h0);
        push(0, 1'b1, 32'h00000033, 2);
        push(1, 1'b1, 32'hEEDDCCBB, 5);
        req = 2'b11;
        run_reqs();
        wait_idle();
        chk("rr_count", 64'(gnt_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            chk("rr_order", 64'(gnt_log[i]), 64'(i % 2));

        // halfword write across 0xFFFF -> 0x10000
        w0 = wr_log.size();
        set_ch(1, 1'b1, 2'd1, 32'h0000FFFF, 32'h0000BEEF);
        push(1, 1'b0, 32'h0, 2);
        req = 2'b10;
        run_reqs();
        wait_idle();
        chk("hw_nwr", 64'(wr_log.size() - w0), 64'd2);
        if (wr_log.size() >= w0 + 2) begin
            chk("hw_b0", 64'(wr_log[w0]), 64'({32'h0000FFFF, 8'hEF}));
            chk("hw_b1", 64'(wr_log[w0+1]), 64'({32'h00010000, 8'hBE}));
        end
        chk("hw_rdata_kept", 64'(rdata_out), 64'hEEDDCCBB);

        // IO write stalled by full buffer
        w0 = wr_log.size();
        io_full = 1'b1;
        set_ch(0, 1'b1, 2'd0, 32'h00030000, 32'h00000041);
        push(0, 1'b0, 32'h0, -1);
        req = 2'b01;
        run_reqs();
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("io_wr_low", 64'(mem_wr), 64'd0);
            chk("io_busy", 64'(busy_out), 64'd1);
        end
        io_full = 1'b0;
        @(negedge clk);
        chk("io_wr", 64'(mem_wr), 64'd1);
        chk("io_a", 64'(mem_a), 64'h30000);
        chk("io_d", 64'(mem_dout), 64'h41);
        wait_idle();
        chk("io_nwr", 64'(wr_log.size() - w0), 64'd1);

        // flush mid word read, pending ch1 served next
        set_ch(0, 1'b0, 2'd2, 32'h100, 32'h0);
        set_ch(1, 1'b0, 2'd0, 32'h203, 32'h0);
        push(1, 1'b1, 32'h000000DD, 2);
        req = 2'b01;
        run_reqs();
        req[1] = 1'b1;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_busy", 64'(busy_out), 64'd0);
        chk("fl_done", 64'(done_out), 64'd0);
        flush = 1'b0;
        run_reqs();
        wait_idle();
        if (gnt_log.size() > 0) chk("fl_next_gnt", 64'(gnt_log[gnt_log.size()-1]), 64'd1);

        // global pause mid word write
        w0 = wr_log.size();
        set_ch(0, 1'b1, 2'd2, 32'h400, 32'hA1B2C3D4);
        push(0, 1'b0, 32'h0, -1);
        req = 2'b01;
        run_reqs();
        @(negedge clk);
        rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("pz_wr", 64'(mem_wr), 64'd0);
            chk("pz_a", 64'(mem_a), 64'h401);
            chk("pz_d", 64'(mem_dout), 64'hC3);
        end
        rdy = 1'b1;
        wait_idle();
        chk("pz_nwr", 64'(wr_log.size() - w0), 64'd4);
        if (wr_log.size() >= w0 + 4) begin
            logic [31:0] wd;
            wd = 32'hA1B2C3D4;
            for (int i = 0; i < 4; i++)
                chk("pz_byte", 64'(wr_log[w0+i]), 64'({32'h400 + 32'(i), wd[8*i +: 8]}));
        end
        chk("pz_mem", 64'({rdm(32'h403), rdm(32'h402), rdm(32'h401), rdm(32'h400)}),
            64'hA1B2C3D4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
